// File: rtl/score_seg_display_if.sv
// rtl/score_seg_display_if.sv - score input and display outputs of the 7-segment score display
interface score_seg_display_if;
   logic [15:0] score;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic        overflow;
   logic        bcd_valid;

   // master: score source and board pins; slave: the display block
   modport master (output score, input an, seg, dp, overflow, bcd_valid);
   modport slave  (input score, output an, seg, dp, overflow, bcd_valid);
endinterface

// File: rtl/score_seg_display.sv
// rtl/score_seg_display.sv - binary score to BCD converter driving a 4-digit multiplexed 7-segment display
module score_seg_display #(
   parameter int SCAN_DIV      = 100000,
   parameter bit BLANK_LEADING = 1'b1
) (
   input logic                 clk,
   input logic                 reset,
   score_seg_display_if.slave  bus
);

   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

   typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

   state_t        state_q;
   logic [35:0]   shift_q;
   logic [35:0]   shift_d;
   logic [4:0]    cnt_q;
   logic [15:0]   last_score_q;
   logic          first_pending_q;
   logic [15:0]   digits_q;        // {d3, d2, d1, d0}
   logic          overflow_q;
   logic          bcd_valid_q;

   logic [PW-1:0] presc_q;
   logic [1:0]    idx_q;

   logic [3:0]    an_q;
   logic [6:0]    seg_q;
   logic          dp_q;
   logic [3:0]    an_d;
   logic [6:0]    seg_d;
   logic [3:0]    cur_digit;
   logic          blank_d;
   logic          zero3;
   logic          zero2;
   logic          zero1;

   // Double-dabble adjust: every BCD nibble >= 5 gets +3 before the shift
   always_comb begin
      shift_d = shift_q;
      for (int i = 0; i < 5; i++) begin
         if (shift_q[16 + 4*i +: 4] >= 4'd5) begin
            shift_d[16 + 4*i +: 4] = shift_q[16 + 4*i +: 4] + 4'd3;
         end
      end
   end

   // Converter FSM: sample on change, 16 shifts, then commit (saturating above 9999)
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q         <= IDLE;
         shift_q         <= '0;
         cnt_q           <= '0;
         last_score_q    <= '0;
         first_pending_q <= 1'b1;
         digits_q        <= '0;
         overflow_q      <= 1'b0;
         bcd_valid_q     <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (first_pending_q || (bus.score != last_score_q)) begin
                  shift_q         <= {20'b0, bus.score};
                  last_score_q    <= bus.score;
                  first_pending_q <= 1'b0;
                  cnt_q           <= 5'd16;
                  state_q         <= SHIFT;
               end
            end
            SHIFT: begin
               shift_q <= {shift_d[34:0], 1'b0};
               cnt_q   <= cnt_q - 5'd1;
               if (cnt_q == 5'd1) begin
                  state_q <= COMMIT;
               end
            end
            COMMIT: begin
               if (shift_q[35:32] != 4'd0) begin
                  digits_q   <= 16'h9999;
                  overflow_q <= 1'b1;
               end else begin
                  digits_q   <= shift_q[31:16];
                  overflow_q <= 1'b0;
               end
               bcd_valid_q <= 1'b1;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Scan prescaler: advance the lit digit once every SCAN_DIV cycles
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc_q <= '0;
         idx_q   <= 2'd0;
      end else if (presc_q == PW'(SCAN_DIV - 1)) begin
         presc_q <= '0;
         idx_q   <= idx_q + 2'd1;
      end else begin
         presc_q <= presc_q + PW'(1);
      end
   end

   // Select the scanned digit, decide leading-zero blanking and encode segments
   always_comb begin
      cur_digit = digits_q[{idx_q, 2'b00} +: 4];
      zero3     = (digits_q[15:12] == 4'd0);
      zero2     = zero3 && (digits_q[11:8] == 4'd0);
      zero1     = zero2 && (digits_q[7:4] == 4'd0);
      blank_d   = 1'b0;
      if (BLANK_LEADING && !overflow_q) begin
         case (idx_q)
            2'd3:    blank_d = zero3;
            2'd2:    blank_d = zero2;
            2'd1:    blank_d = zero1;
            default: blank_d = 1'b0;
         endcase
      end
      case (cur_digit)
         4'd0:    seg_d = 7'b1000000;
         4'd1:    seg_d = 7'b1111001;
         4'd2:    seg_d = 7'b0100100;
         4'd3:    seg_d = 7'b0110000;
         4'd4:    seg_d = 7'b0011001;
         4'd5:    seg_d = 7'b0010010;
         4'd6:    seg_d = 7'b0000010;
         4'd7:    seg_d = 7'b1111000;
         4'd8:    seg_d = 7'b0000000;
         4'd9:    seg_d = 7'b0010000;
         default: seg_d = 7'b1111111;
      endcase
      if (blank_d) begin
         seg_d = 7'b1111111;
      end
      an_d = ~(4'b0001 << idx_q);
   end

   // Output registers for anodes, segments and decimal point
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         an_q  <= 4'b1110;
         seg_q <= 7'b1000000;
         dp_q  <= 1'b1;
      end else begin
         an_q  <= an_d;
         seg_q <= seg_d;
         dp_q  <= ~overflow_q;
      end
   end

   assign bus.an        = an_q;
   assign bus.seg       = seg_q;
   assign bus.dp        = dp_q;
   assign bus.overflow  = overflow_q;
   assign bus.bcd_valid = bcd_valid_q;

endmodule

// File: tb/tb_score_seg_display.sv
// tb/tb_score_seg_display.sv - scoreboard bench for score_seg_display
module tb_score_seg_display;

   localparam logic [6:0] S0 = 7'b1000000;
   localparam logic [6:0] S1 = 7'b1111001;
   localparam logic [6:0] S2 = 7'b0100100;
   localparam logic [6:0] S3 = 7'b0110000;
   localparam logic [6:0] S4 = 7'b0011001;
   localparam logic [6:0] S5 = 7'b0010010;
   localparam logic [6:0] S7 = 7'b1111000;
   localparam logic [6:0] S9 = 7'b0010000;
   localparam logic [6:0] SB = 7'b1111111;

   typedef struct {
      int          id;
      bit          use_b;
      logic [27:0] segs;   // {d3, d2, d1, d0}
      logic        dp;
      logic        ovf;
   } exp_t;

   logic        clk;
   logic        reset;
   logic [15:0] score;

   int   checks;
   int   failures;
   exp_t sb_q[$];
   bit   mon_busy;

   bit   watch4;
   bit   saw2, saw4, saw5, saw7, bad4;

   score_seg_display_if ifa ();
   score_seg_display_if ifb ();

   assign ifa.score = score;
   assign ifb.score = score;

   score_seg_display #(.SCAN_DIV(4), .BLANK_LEADING(1'b1)) dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (ifa)
   );

   score_seg_display #(.SCAN_DIV(4), .BLANK_LEADING(1'b0)) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (ifb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic logic [3:0] an_of(input bit b);
      return b ? ifb.an : ifa.an;
   endfunction

   function automatic logic [6:0] seg_of(input bit b);
      return b ? ifb.seg : ifa.seg;
   endfunction

   function automatic logic dp_of(input bit b);
      return b ? ifb.dp : ifa.dp;
   endfunction

   // Monitor: pops an expected frame and compares each digit as the DUT scans it
   initial begin
      exp_t        e;
      logic [3:0]  want;
      int          n;
      mon_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (sb_q.size() > 0) begin
            e        = sb_q.pop_front();
            mon_busy = 1'b1;
            check($sformatf("f%0d_ovf", e.id), e.use_b ? ifb.overflow : ifa.overflow, e.ovf);
            for (int k = 0; k < 4; k++) begin
               want = ~(4'b0001 << k);
               n    = 0;
               while (an_of(e.use_b) !== want && n < 64) begin
                  @(negedge clk);
                  n++;
               end
               if (n >= 64) begin
                  check($sformatf("f%0d_an_timeout_d%0d", e.id, k), an_of(e.use_b), want);
               end else begin
                  check($sformatf("f%0d_seg_d%0d", e.id, k), seg_of(e.use_b), e.segs[k*7 +: 7]);
                  check($sformatf("f%0d_dp_d%0d", e.id, k), dp_of(e.use_b), e.dp);
               end
            end
            mon_busy = 1'b0;
         end
      end
   end

   // Watches the display during the 42 -> 57 sequence for any unexpected segment pattern
   always @(negedge clk) begin
      if (watch4) begin
         case (ifa.an)
            4'b1110: begin
               if (ifa.seg == S2) saw2 = 1'b1;
               else if (ifa.seg == S7) saw7 = 1'b1;
               else bad4 = 1'b1;
            end
            4'b1101: begin
               if (ifa.seg == S4) saw4 = 1'b1;
               else if (ifa.seg == S5) saw5 = 1'b1;
               else bad4 = 1'b1;
            end
            4'b1011, 4'b0111: begin
               if (ifa.seg != SB) bad4 = 1'b1;
            end
            default: bad4 = 1'b1;
         endcase
      end
   end

   task automatic expect_frame(input int id, input bit b, input logic [6:0] s3, input logic [6:0] s2,
                               input logic [6:0] s1, input logic [6:0] s0, input logic dp, input logic ovf);
      exp_t e;
      int   n;
      e.id    = id;
      e.use_b = b;
      e.segs  = {s3, s2, s1, s0};
      e.dp    = dp;
      e.ovf   = ovf;
      sb_q.push_back(e);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while ((sb_q.size() != 0 || mon_busy) && n < 400);
      if (n >= 400) begin
         checks++;
         failures++;
         $display("FAIL f%0d_drain_timeout actual=pending expected=drained", id);
      end
   endtask

   task automatic set_score(input logic [15:0] v);
      @(negedge clk);
      score = v;
      repeat (20) @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_an_a"}, ifa.an, 4'b1110);
      check({tag, "_seg_a"}, ifa.seg, S0);
      check({tag, "_dp_a"}, ifa.dp, 1'b1);
      check({tag, "_ovf_a"}, ifa.overflow, 1'b0);
      check({tag, "_valid_a"}, ifa.bcd_valid, 1'b0);
      check({tag, "_an_b"}, ifb.an, 4'b1110);
      check({tag, "_valid_b"}, ifb.bcd_valid, 1'b0);
   endtask

   task automatic check_latency(input string tag);
      repeat (17) @(posedge clk);
      #1;
      check({tag, "_valid_at17"}, ifa.bcd_valid, 1'b0);
      @(posedge clk);
      #1;
      check({tag, "_valid_at18"}, ifa.bcd_valid, 1'b1);
      check({tag, "_ovf_at18"}, ifa.overflow, 1'b0);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      watch4   = 1'b0;
      saw2 = 1'b0; saw4 = 1'b0; saw5 = 1'b0; saw7 = 1'b0; bad4 = 1'b0;
      reset    = 1'b1;
      score    = 16'd0;

      // 1: reset state, first conversion latency, score 0 display
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("t1_reset");
      @(negedge clk);
      reset = 1'b0;
      check_latency("t1");
      expect_frame(1, 1'b0, SB, SB, SB, S0, 1'b1, 1'b0);

      // 2: 1234
      set_score(16'd1234);
      expect_frame(2, 1'b0, S1, S2, S3, S4, 1'b1, 1'b0);

      // 3: overflow boundary and saturation, then back to 9999
      set_score(16'd10000);
      expect_frame(3, 1'b0, S9, S9, S9, S9, 1'b0, 1'b1);
      set_score(16'd65535);
      expect_frame(4, 1'b0, S9, S9, S9, S9, 1'b0, 1'b1);
      set_score(16'd9999);
      expect_frame(5, 1'b0, S9, S9, S9, S9, 1'b1, 1'b0);

      // 4: 42, changed to 57 while the converter is busy
      @(negedge clk);
      score = 16'd42;
      @(posedge clk);
      repeat (3) @(posedge clk);
      @(negedge clk);
      score = 16'd57;
      repeat (15) @(posedge clk);
      #1;
      watch4 = 1'b1;
      repeat (45) @(posedge clk);
      #1;
      watch4 = 1'b0;
      check("t4_saw42", {saw2, saw4}, 2'b11);
      check("t4_saw57", {saw7, saw5}, 2'b11);
      check("t4_no_garbage", bad4, 1'b0);
      expect_frame(6, 1'b0, SB, SB, S5, S7, 1'b1, 1'b0);

      // 5: blanking on vs off
      set_score(16'd7);
      expect_frame(7, 1'b0, SB, SB, SB, S7, 1'b1, 1'b0);
      expect_frame(8, 1'b1, S0, S0, S0, S7, 1'b1, 1'b0);

      // 6: reset in the middle of a conversion of 500
      @(negedge clk);
      score = 16'd500;
      @(posedge clk);
      repeat (8) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check_reset_outputs("t6_reset");
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      check_latency("t6");
      expect_frame(9, 1'b0, SB, S5, S0, S0, 1'b1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=running expected=finished");
      $fatal(1, "watchdog");
   end

endmodule
